// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the byte-serial memory bus responder.
package mem_io_responder_pkg;

  localparam logic [31:0] IO_OUT_ADDR   = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR  = 32'h0003_0004;
  localparam logic [1:0]  IO_REGION_SEL = 2'b11;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ACC_RAM      = 2'd0,
    ACC_IO_OUT   = 2'd1,
    ACC_IO_HALT  = 2'd2,
    ACC_IO_OTHER = 2'd3
  } access_e;

  // Bits [17:16] pick the IO region; inside it only the two exact ports are live.
  function automatic access_e decode_access(input logic [31:0] addr);
    if (addr[17:16] != IO_REGION_SEL) return ACC_RAM;
    if (addr == IO_OUT_ADDR)          return ACC_IO_OUT;
    if (addr == IO_HALT_ADDR)         return ACC_IO_HALT;
    return ACC_IO_OTHER;
  endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// tx_byte_fifo: synchronous byte FIFO with occupancy output; pushes into a full FIFO are dropped.
module tx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head       = mem[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped TX port and halt port on the controller's byte bus.
// Optional HALT_DRAIN_EN: the halt write waits for the TX FIFO to empty before halt_out rises.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int TX_GAP     = 0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_write,
  input  logic        r_nw_in,
  output logic [7:0]  mem_read,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  access_e               acc;
  logic                  is_rd, is_wr, ram_we, push, pop, halt_wr;
  logic [CW-1:0]         count, count_next;

  logic [7:0]    mem_read_q, mem_read_d;
  logic          full_q, full_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          halt_q, halt_d;

  assign idx     = mem_addr[ADDR_WIDTH-1:0];
  assign acc     = decode_access(mem_addr);
  assign is_rd   = rdy_in && (r_nw_in == BUS_READ);
  assign is_wr   = rdy_in && (r_nw_in == BUS_WRITE);
  assign ram_we  = is_wr && (acc == ACC_RAM);
  assign push    = is_wr && (acc == ACC_IO_OUT);
  assign halt_wr = is_wr && (acc == ACC_IO_HALT);
  assign pop     = rdy_in && tx_valid && tx_ready && (gap_q == '0);

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push       (push),
    .push_data  (mem_write),
    .pop        (pop),
    .head       (tx_data),
    .count      (count),
    .count_next (count_next)
  );

  assign tx_valid = (count != '0);

  always_comb begin
    mem_read_d = mem_read_q;
    full_d     = full_q;
    gap_d      = gap_q;
    if (is_rd) mem_read_d = (acc == ACC_RAM) ? ram[idx] : 8'h00;
    // Two entries of slack: one for the flag's own lag, one for a write already on the bus.
    if (rdy_in) full_d = (count_next >= CW'(FIFO_DEPTH - 2));
    if (rdy_in) begin
      if (pop)               gap_d = GW'(TX_GAP);
      else if (gap_q != '0)  gap_d = gap_q - GW'(1);
    end
  end

`ifdef HALT_DRAIN_EN
  logic pend_q, pend_d;

  always_comb begin
    pend_d = pend_q | halt_wr;
    halt_d = halt_q | (rdy_in && pend_q && (count == '0));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pend_q <= 1'b0;
    else           pend_q <= pend_d;
  end
`else
  always_comb begin
    halt_d = halt_q | halt_wr;
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_read_q <= 8'h00;
      full_q     <= 1'b0;
      gap_q      <= '0;
      halt_q     <= 1'b0;
    end else begin
      mem_read_q <= mem_read_d;
      full_q     <= full_d;
      gap_q      <= gap_d;
      halt_q     <= halt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[idx] <= mem_write;
  end

  assign mem_read       = mem_read_q;
  assign io_buffer_full = full_q;
  assign halt_out       = halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: scoreboard queues for TX bytes and read data,
// plus a second instance with TX_GAP=2 for pop spacing.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic        r_nw;
  logic [7:0]  mem_read;
  logic        full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  logic [31:0] g_addr;
  logic [7:0]  g_wdata;
  logic        g_r_nw;
  logic [7:0]  g_mem_read;
  logic        g_full;
  logic [7:0]  g_tx_data;
  logic        g_tx_valid;
  logic        g_tx_ready;
  logic        g_halt;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic       rd_strobe = 1'b0;
  logic       rd_strobe_q = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .mem_addr       (addr),
    .mem_write      (wdata),
    .r_nw_in        (r_nw),
    .mem_read       (mem_read),
    .io_buffer_full (full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .halt_out       (halt)
  );

  mem_io_responder #(.TX_GAP(2)) dut_gap (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (1'b1),
    .mem_addr       (g_addr),
    .mem_write      (g_wdata),
    .r_nw_in        (g_r_nw),
    .mem_read       (g_mem_read),
    .io_buffer_full (g_full),
    .tx_data        (g_tx_data),
    .tx_valid       (g_tx_valid),
    .tx_ready       (g_tx_ready),
    .halt_out       (g_halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_strobe_q <= 1'b0;
    else        rd_strobe_q <= rd_strobe && rdy;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (rd_strobe_q) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no read", mem_read);
        end else begin
          check("mem_read", {24'd0, mem_read}, {24'd0, rd_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    addr = 32'h0003_000C; wdata = 8'h00; r_nw = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; r_nw = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    addr = a; r_nw = 1'b1; rd_strobe = 1'b1;
    rd_q.push_back(exp);
  endtask

  // Let the last driven beat be captured, then sample mid-cycle.
  task automatic settle();
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d, input bit expect_out);
    bus_wr(32'h0003_0000, d);
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!tx_valid) break;
    end
    check("drain_done", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  task automatic g_wr(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    g_addr = a; g_wdata = d; g_r_nw = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         pops[$];
    logic [7:0] prev;
    logic       last_valid;

    rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0;
    bus_idle();
    g_addr = 32'h0003_000C; g_wdata = 8'h00; g_r_nw = 1'b0; g_tx_ready = 1'b0;
    #12;
    check("rst_mem_read", {24'd0, mem_read}, 32'd0);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_halt",     {31'd0, halt},     32'd0);
    @(negedge clk); rst_n = 1'b1;

    // RAM write/read, write cycle leaves mem_read alone, aliasing, IO read
    bus_wr(32'h0000_0010, 8'hA5);
    settle();
    check("wr_holds_read", {24'd0, mem_read}, 32'd0);
    bus_rd(32'h0000_0010, 8'hA5);
    settle();
    bus_wr(32'h0002_0011, 8'h5A);
    settle();
    check("wr_holds_read2", {24'd0, mem_read}, 32'h0000_00A5);
    bus_rd(32'h0000_0011, 8'h5A);
    bus_rd(32'h0003_0000, 8'h00);
    settle();

    // Six pushes with no sink: full asserts exactly after the 6th
    for (int i = 0; i < 5; i++) push_tx(8'h41, 1'b1);
    settle();
    check("full_at_5", {31'd0, full}, 32'd0);
    push_tx(8'h41, 1'b1);
    settle();
    check("full_at_6",  {31'd0, full},     32'd1);
    check("head_41",    {24'd0, tx_data},  32'h0000_0041);
    check("valid_at_6", {31'd0, tx_valid}, 32'd1);
    drain();
    check("full_after_drain", {31'd0, full}, 32'd0);

    // Overflow: ninth byte dropped, then drain and watch the full flag fall at count 5
    for (int i = 1; i <= 9; i++) push_tx(8'(i), i <= 8);
    settle();
    check("ovf_full", {31'd0, full},    32'd1);
    check("ovf_head", {24'd0, tx_data}, 32'h0000_0001);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("drain_full",  {31'd0, full},     {31'd0, (8 - k) >= 6});
      check("drain_valid", {31'd0, tx_valid}, {31'd0, k < 8});
    end
    tx_ready = 1'b0;
    check("ovf_all_popped", exp_q.size(), 32'd0);

    // Halt: unrelated IO write is discarded; halt port write with two bytes queued
    push_tx(8'h61, 1'b1);
    push_tx(8'h62, 1'b1);
    bus_wr(32'h0003_0008, 8'hFF);
    settle();
    check("io_other_halt",  {31'd0, halt},    32'd0);
    check("io_other_head",  {24'd0, tx_data}, 32'h0000_0061);
    bus_wr(32'h0003_0004, 8'h01);
    settle();
`ifdef HALT_DRAIN_EN
    check("halt_pending", {31'd0, halt}, 32'd0);
`else
    check("halt_set", {31'd0, halt}, 32'd1);
`endif
    drain();
    settle();
    check("halt_after_drain", {31'd0, halt}, 32'd1);

    // Asynchronous reset with bytes queued
    for (int i = 0; i < 6; i++) push_tx(8'hC0 + 8'(i), 1'b0);
    settle();
    check("pre_rst_full",  {31'd0, full},     32'd1);
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rst_full",  {31'd0, full},     32'd0);
    check("async_rst_halt",  {31'd0, halt},     32'd0);
    @(negedge clk); rst_n = 1'b1;

    // rdy low freezes everything
    rdy = 1'b0;
    bus_wr(32'h0000_0010, 8'h77);
    bus_wr(32'h0003_0000, 8'h99);
    bus_wr(32'h0003_0004, 8'h01);
    settle();
    check("frz_valid", {31'd0, tx_valid}, 32'd0);
    check("frz_halt",  {31'd0, halt},     32'd0);
    check("frz_read",  {24'd0, mem_read}, 32'd0);
    rdy = 1'b1;
    bus_rd(32'h0000_0010, 8'hA5);
    settle();

    // TX_GAP=2 instance: three queued bytes pop on edges N, N+3, N+6
    g_wr(32'h0003_0000, 8'h11);
    g_wr(32'h0003_0000, 8'h22);
    g_wr(32'h0003_0000, 8'h33);
    @(posedge clk); #1;
    g_addr = 32'h0003_000C;
    @(negedge clk);
    check("gap_head", {24'd0, g_tx_data}, 32'h0000_0011);
    @(posedge clk); #1;
    g_tx_ready = 1'b1;
    prev = 8'h11;
    last_valid = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (last_valid && (!g_tx_valid || g_tx_data !== prev)) pops.push_back(e);
      prev = g_tx_data;
      last_valid = g_tx_valid;
    end
    g_tx_ready = 1'b0;
    check("gap_pop_count", pops.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("gap_pop_edge", (i < pops.size()) ? pops[i] : 32'hFFFF_FFFF, 32'(3 * i));
    end

    repeat (2) @(negedge clk);
    check("tx_queue_empty", exp_q.size(), 32'd0);
    check("rd_queue_empty", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
